// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, FSM state encoding and saturation helpers for the PID term scheduler
package pid_pkg;
   localparam int E_W    = 6;
   localparam int K_W    = 6;
   localparam int OP_W   = 8;
   localparam int PROD_W = 14;
   localparam int SUM_W  = 16;
   typedef enum logic [2:0] {IDLE, CAPTURE, MUL_P, MUL_I, MUL_D, SUM} state_e;
   function automatic logic signed [5:0] sat6(input logic signed [SUM_W-1:0] x);
      return (x > 16'sd31) ? 6'b011111 : (x < -16'sd32) ? 6'b100000 : x[5:0];
   endfunction
   function automatic logic signed [7:0] sat8(input logic signed [8:0] x);
      return (x > 9'sd127) ? 8'h7f : (x < -9'sd128) ? 8'h80 : x[7:0];
   endfunction
endpackage

// File: rtl/pid_term_scheduler_mul.sv
// shared_rep_mul: iterative signed x unsigned multiplier, adds a once per cycle b times
// Ports: clk_i/rst_i/ena_i clock, sync reset, clock enable; load_i starts a product of
// a_i (8-bit signed) by b_i (6-bit unsigned); done_o is high for the single cycle prod_o is final.
module shared_rep_mul
   import pid_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     ena_i,
   input  logic                     load_i,
   input  logic signed [OP_W-1:0]   a_i,
   input  logic        [K_W-1:0]    b_i,
   output logic                     done_o,
   output logic signed [PROD_W-1:0] prod_o
);
   logic signed [OP_W-1:0]   a_q;
   logic        [K_W-1:0]    cnt_q;
   logic signed [PROD_W-1:0] acc_q;
   logic                     run_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_q   <= '0;
         cnt_q <= '0;
         acc_q <= '0;
         run_q <= 1'b0;
      end else if (ena_i) begin
         if (load_i) begin
            a_q   <= a_i;
            cnt_q <= b_i;
            acc_q <= '0;
            run_q <= 1'b1;
         end else if (run_q && cnt_q != '0) begin
            acc_q <= acc_q + PROD_W'(a_q);
            cnt_q <= cnt_q - K_W'(1);
         end else begin
            run_q <= 1'b0;
         end
      end
   end
   // Done once the count is exhausted, so b=0 finishes one cycle after load.
   assign done_o = run_q && cnt_q == '0;
   assign prod_o = acc_q;
endmodule

// File: rtl/pid_term_scheduler.sv
// pid_term_scheduler: PID controller sequencing P, I and D terms through one shared multiplier
// Ports: clk_i/rst_i/ena_i clock, sync reset, clock enable; start_i sample request with error e_i;
// k_p_i/k_i_i/k_d_i gains latched at capture; clear_int_i zeroes the integral when idle;
// busy_o high while not idle; u_o saturated control output with u_valid_o pulse; integ_o integral.
module pid_term_scheduler
   import pid_pkg::*;
#(
   parameter int OUT_SHIFT = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ena_i,
   input  logic                  start_i,
   input  logic signed [E_W-1:0] e_i,
   input  logic        [K_W-1:0] k_p_i,
   input  logic        [K_W-1:0] k_i_i,
   input  logic        [K_W-1:0] k_d_i,
   input  logic                  clear_int_i,
   output logic                  busy_o,
   output logic signed [E_W-1:0] u_o,
   output logic                  u_valid_o,
   output logic signed [7:0]     integ_o
);
   state_e                   state_q, state_d;
   logic signed [E_W-1:0]    e_cap_q, e_cap_d, e_prior_q, e_prior_d, u_q, u_d;
   logic signed [6:0]        diff_q, diff_d;
   logic signed [7:0]        integ_q, integ_d;
   logic        [K_W-1:0]    kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
   logic signed [PROD_W-1:0] p_prod_q, p_prod_d, i_prod_q, i_prod_d, d_prod_q, d_prod_d;
   logic                     u_valid_q, u_valid_d;
   logic                     mul_load, mul_done;
   logic signed [OP_W-1:0]   mul_a;
   logic        [K_W-1:0]    mul_b;
   logic signed [PROD_W-1:0] mul_prod;
   logic signed [SUM_W-1:0]  sum;
   shared_rep_mul u_mul (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .ena_i  (ena_i),
      .load_i (mul_load),
      .a_i    (mul_a),
      .b_i    (mul_b),
      .done_o (mul_done),
      .prod_o (mul_prod)
   );
   always_comb begin
      state_d   = state_q;
      e_cap_d   = e_cap_q;
      e_prior_d = e_prior_q;
      diff_d    = diff_q;
      integ_d   = integ_q;
      kp_d      = kp_q;
      ki_d      = ki_q;
      kd_d      = kd_q;
      p_prod_d  = p_prod_q;
      i_prod_d  = i_prod_q;
      d_prod_d  = d_prod_q;
      u_d       = u_q;
      u_valid_d = 1'b0;
      mul_load  = 1'b0;
      mul_a     = '0;
      mul_b     = '0;
      sum       = SUM_W'(p_prod_q) + SUM_W'(i_prod_q) + SUM_W'(d_prod_q);
      case (state_q)
         IDLE: begin
            if (start_i) begin
               e_cap_d = e_i;
               state_d = CAPTURE;
            end else if (clear_int_i) begin
               integ_d = '0;
            end
         end
         CAPTURE: begin
            diff_d    = 7'(e_cap_q) - 7'(e_prior_q);
            integ_d   = sat8(9'(integ_q) + 9'(e_cap_q));
            e_prior_d = e_cap_q;
            kp_d      = k_p_i;
            ki_d      = k_i_i;
            kd_d      = k_d_i;
            mul_load  = 1'b1;
            mul_a     = OP_W'(e_cap_q);
            mul_b     = k_p_i;
            state_d   = MUL_P;
         end
         MUL_P: begin
            if (mul_done) begin
               p_prod_d = mul_prod;
               mul_load = 1'b1;
               mul_a    = integ_q;
               mul_b    = ki_q;
               state_d  = MUL_I;
            end
         end
         MUL_I: begin
            if (mul_done) begin
               i_prod_d = mul_prod;
               mul_load = 1'b1;
               mul_a    = OP_W'(diff_q);
               mul_b    = kd_q;
               state_d  = MUL_D;
            end
         end
         MUL_D: begin
            if (mul_done) begin
               d_prod_d = mul_prod;
               state_d  = SUM;
            end
         end
         SUM: begin
            u_d       = sat6(sum >>> OUT_SHIFT);
            u_valid_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         e_cap_q   <= '0;
         e_prior_q <= '0;
         diff_q    <= '0;
         integ_q   <= '0;
         kp_q      <= '0;
         ki_q      <= '0;
         kd_q      <= '0;
         p_prod_q  <= '0;
         i_prod_q  <= '0;
         d_prod_q  <= '0;
         u_q       <= '0;
         u_valid_q <= 1'b0;
      end else begin
         // The pulse register runs every cycle so a frozen SUM cannot leave it stuck high.
         u_valid_q <= ena_i & u_valid_d;
         if (ena_i) begin
            state_q   <= state_d;
            e_cap_q   <= e_cap_d;
            e_prior_q <= e_prior_d;
            diff_q    <= diff_d;
            integ_q   <= integ_d;
            kp_q      <= kp_d;
            ki_q      <= ki_d;
            kd_q      <= kd_d;
            p_prod_q  <= p_prod_d;
            i_prod_q  <= i_prod_d;
            d_prod_q  <= d_prod_d;
            u_q       <= u_d;
         end
      end
   end
   assign busy_o    = state_q != IDLE;
   assign u_o       = u_q;
   assign u_valid_o = u_valid_q & ena_i;
   assign integ_o   = integ_q;
endmodule

// File: tb/tb_pid_term_scheduler.sv
// tb_pid_term_scheduler: directed stimulus with a queued scoreboard checked on each u_valid
module tb_pid_term_scheduler;
   logic clk = 1'b0, rst = 1'b1, ena = 1'b1, start = 1'b0, clear_int = 1'b0;
   logic signed [5:0] e = '0;
   logic [5:0] kp = '0, ki = '0, kd = '0;
   logic busy, busy2, u_valid, u_valid2;
   logic signed [5:0] u, u2;
   logic signed [7:0] integ, integ2;
   int cyc = 0, n_chk = 0, n_fail = 0, t0 = 0;
   typedef struct {int u; int u2; int integ; int cyc;} exp_t;
   exp_t sb[$];
   exp_t mx;
   int iu[6]  = '{-30, -32, -32, -32, -32, -32};
   int iu2[6] = '{-8, -15, -23, -30, -32, -32};
   int ii[6]  = '{-30, -60, -90, -120, -128, -128};
   pid_term_scheduler #(.OUT_SHIFT(0)) dut (
      .clk_i(clk), .rst_i(rst), .ena_i(ena), .start_i(start), .e_i(e),
      .k_p_i(kp), .k_i_i(ki), .k_d_i(kd), .clear_int_i(clear_int),
      .busy_o(busy), .u_o(u), .u_valid_o(u_valid), .integ_o(integ));
   pid_term_scheduler #(.OUT_SHIFT(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .ena_i(ena), .start_i(start), .e_i(e),
      .k_p_i(kp), .k_i_i(ki), .k_d_i(kd), .clear_int_i(clear_int),
      .busy_o(busy2), .u_o(u2), .u_valid_o(u_valid2), .integ_o(integ2));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask
   always @(negedge clk) begin
      if (u_valid) begin
         if (sb.size() == 0) chk("unexpected_u_valid", 1, 0);
         else begin
            mx = sb.pop_front();
            chk("u", u, mx.u);
            chk("u_shift2", u2, mx.u2);
            chk("integ", integ, mx.integ);
            chk("u_valid_cycle", cyc, mx.cyc);
         end
      end
   end
   task automatic issue(input int ev, kpv, kiv, kdv, input bit push, input int eu, eu2, ein, lat);
      @(negedge clk);
      e = 6'(ev); kp = 6'(kpv); ki = 6'(kiv); kd = 6'(kdv); start = 1'b1;
      @(posedge clk);
      #1 t0 = cyc;
      if (push) sb.push_back('{eu, eu2, ein, t0 + lat});
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic wait_idle(input int exp_busy);
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
      else chk("busy_len", cyc - t0, exp_busy);
   endtask
   task automatic clr();
      @(negedge clk);
      clear_int = 1'b1;
      @(negedge clk);
      clear_int = 1'b0;
      chk("clear_int", integ, 0);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_u", u, 0);
      chk("rst_u_valid", u_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_integ", integ, 0);
      issue(10, 0, 0, 1, 1, 10, 2, 10, 6);
      wait_idle(6);
      issue(4, 0, 0, 1, 1, -6, -2, 14, 6);
      wait_idle(6);
      clr();
      issue(5, 3, 0, 0, 1, 15, 3, 5, 8);
      wait_idle(8);
      clr();
      for (int i = 0; i < 6; i++) begin
         issue(-30, 0, 1, 0, 1, iu[i], iu2[i], ii[i], 6);
         wait_idle(6);
      end
      clr();
      issue(31, 63, 0, 0, 1, 31, 31, 31, 68);
      wait_idle(68);
      clr();
      issue(20, 1, 1, 1, 1, 29, 7, 20, 8);
      repeat (4) @(negedge clk);
      start = 1'b1; kp = 6'd63; ki = 6'd63; kd = 6'd63; e = -6'sd20;
      @(negedge clk);
      start = 1'b0;
      wait_idle(8);
      kp = '0; ki = '0; kd = '0;
      repeat (3) @(negedge clk);
      chk("start_not_queued", busy, 0);
      issue(5, 4, 0, 0, 1, 20, 5, 25, 13);
      repeat (2) @(negedge clk);
      ena = 1'b0;
      repeat (4) @(negedge clk);
      chk("u_hold_ena_low", u, 29);
      ena = 1'b1;
      wait_idle(13);
      issue(10, 1, 1, 2, 0, 0, 0, 0, 0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_u", u, 0);
      chk("rst_mid_integ", integ, 0);
      repeat (12) @(negedge clk);
      chk("u_after_rst", u, 0);
      issue(7, 0, 0, 1, 1, 7, 1, 7, 6);
      wait_idle(6);
      repeat (2) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pid_term_scheduler.md
# pid_term_scheduler

Sequences one shared repeated-add multiplier across the proportional, integral and derivative terms of the PID controller. Dedicated per-term multipliers do not fit the tile area budget, so the block time-multiplexes one multiplier. On each sample request it captures the error, updates the difference and saturating integral, runs three multiplications in turn, then sums, scales and saturates the result into the 6-bit control output. It sits between the error source and the actuator output and owns all PID history state.

## Interface
- OUT_SHIFT, 0: arithmetic right shift applied to the 16-bit term sum before output saturation.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ena  in  1  clock enable; low holds every register.
- start  in  1  sample request; accepted only in IDLE with ena=1.
- e  in  6  signed error, sampled on the accepting edge.
- K_p, K_i, K_d  in  6 each  unsigned gains 0..63, latched in CAPTURE.
- clear_int  in  1  zeroes the integral in IDLE; ignored while busy.
- busy  out  1  high whenever state is not IDLE.
- u  out  6  signed control output, saturated to -32..31; holds its value between updates.
- u_valid  out  1  registered one-cycle pulse AND ena; high on the cycle u updates.
- integ  out  8  signed integral accumulator, for observability.

## Operation
- States are IDLE, CAPTURE, MUL_P, MUL_I, MUL_D and SUM.
- **IDLE**: on start&ena, latch e into e_cap and go to CAPTURE. Otherwise, if clear_int, set integ to 0.
- **CAPTURE**:
  - diff is 7-bit signed, diff = e_cap - e_prior (range -63..63).
  - integ = sat8(integ + e_cap), clamped to -128..127.
  - e_prior <= e_cap; latch the three gains.
  - Load the multiplier with (sign-extended e_cap, K_p); go to MUL_P.
- **MUL_P, MUL_I, MUL_D**:
  - Each state waits for mul_done, stores its 14-bit signed product, loads the next operand pair and advances.
  - Operand pairs are (e_cap, K_p), (integ, K_i) and (diff, K_d), all sign-extended to 8 bits.
  - MUL_D advances to SUM.
- **SUM**:
  - s = p_prod + i_prod + d_prod, 16-bit signed, no overflow possible.
  - u <= sat6(s >>> OUT_SHIFT); u_valid pulse; go to IDLE.
- **Multiplier**: 8-bit signed a × 6-bit unsigned b → 14-bit signed product. It adds a once per cycle, b times. mul_done pulses on the (b+1)-th cycle after load; b=0 gives product 0 with done after 1 cycle.
- **Boundary conditions**:
  - start while busy is ignored and not queued.
  - Gain changes mid-operation have no effect until the next CAPTURE.
  - rst mid-operation: next edge enters IDLE and clears multiplier, products, integ, e_prior, e_cap, diff and u. No u_valid is produced.
  - ena low freezes the FSM, multiplier and all registers mid-operation and forces u_valid low. The operation resumes exactly where it stopped.
- **Reset values**: u=0, u_valid=0, busy=0, integ=0, e_prior=0, state IDLE.

## Timing
- Edge 0 is the accepting edge. u and u_valid update at edge K_p+K_i+K_d+5, with ena held high throughout.
- busy is high for exactly K_p+K_i+K_d+5 cycles, starting the cycle after edge 0 and ending on the u_valid cycle.
- start may be reasserted on the u_valid cycle; the FSM is already in IDLE then. Back-to-back throughput is therefore one sample per K_p+K_i+K_d+5 cycles.
- The minimum latency is 5 cycles, with all gains 0.

## Structure
- Package pid_pkg holds:
  - the widths E_W=6, K_W=6, OP_W=8, PROD_W=14, SUM_W=16;
  - the FSM state enum;
  - the sat6 and sat8 saturation functions.
- Sub-module shared_rep_mul implements the load/done iterative multiplier. It contains the down-counter and accumulator, and its load and done signals are its only handshake.
- FSM, history registers and output stage live in pid_term_scheduler.

## Test plan
- P only: K_p=3, K_i=K_d=0, e=5, start → u=15 with u_valid at edge 8, busy high for 8 cycles.
- D only: K_d=1, e=10 then e=4 → u=10, then u=-6.
- Integral saturation: K_i=1, e=-30 for six samples → integ = -30, -60, -90, -120, -128, -128; u=-30, then -32 from the second sample onward.
- Output scaling: OUT_SHIFT=2, K_p=63, e=31 → s=1953, s>>>2 = 488 → u=31.
- Protocol: start pulsed mid-MUL_I is ignored. Gains changed mid-operation have no effect. ena low for 4 cycles in MUL_P delays u_valid by exactly 4 cycles with an unchanged u.
- Reset and clear: rst during MUL_D → no u_valid, u=0, integ=0. clear_int in IDLE → integ=0 next cycle.
